// File: rtl/sn76489_wr_arbiter.sv
// Round-robin arbiter sharing one SN76489 CPU write port; encodes register writes into latch/data bytes.
// Optional macro SN76489_WR_SHADOW_EN adds an 8 x 10-bit shadow of the values actually written.

module sn76489_wr_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned RDY_TIMEOUT = 64
) (
    input  logic                    clock_i,
    input  logic                    res_n_i,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [3*NUM_REQ-1:0]    reg_i,
    input  logic [10*NUM_REQ-1:0]   data_i,
    output logic [NUM_REQ-1:0]      ack_o,
    output logic                    busy_o,
    output logic [2:0]              grant_o,
    output logic                    ce_n_o,
    output logic                    we_n_o,
    output logic [7:0]              d_o,
    input  logic                    ready_i,
`ifdef SN76489_WR_SHADOW_EN
    output logic                    timeout_o,
    input  logic [2:0]              shadow_addr_i,
    output logic [9:0]              shadow_data_o
`else
    output logic                    timeout_o
`endif
);

    localparam int unsigned      CNT_W    = $clog2(RDY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RDY_TIMEOUT - 1);
    localparam logic [2:0]       LAST_REQ = 3'(NUM_REQ - 1);

    typedef enum logic [2:0] {IDLE, ARB, STROBE, WAIT_HI, GAP, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         grant_q, grant_d;
    logic [2:0]         reg_q, reg_d;
    logic [9:0]         data_q, data_d;
    logic               second_q, second_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               strobe_n_q, strobe_n_d;
    logic [7:0]         d_q, d_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic               found;
    logic [2:0]         pick_idx;
    logic [2:0]         pick_reg;
    logic [9:0]         pick_data;

    function automatic logic is_freq(input logic [2:0] r);
        return !r[0] && (r != 3'd6);
    endfunction

    // Noise control only carries 3 bits; bit 3 of its latch byte is forced low.
    function automatic logic [7:0] latch_byte(input logic [2:0] r, input logic [3:0] lo);
        return {1'b1, r, (r == 3'd6) ? {1'b0, lo[2:0]} : lo};
    endfunction

    // First requester at or above the pointer wins, else the first below it.
    always_comb begin : arbitrate
        found     = 1'b0;
        pick_idx  = 3'd0;
        pick_reg  = 3'd0;
        pick_data = 10'd0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i] && (3'(i) >= ptr_q)) begin
                found     = 1'b1;
                pick_idx  = 3'(i);
                pick_reg  = reg_i[3*i +: 3];
                pick_data = data_i[10*i +: 10];
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i]) begin
                found     = 1'b1;
                pick_idx  = 3'(i);
                pick_reg  = reg_i[3*i +: 3];
                pick_data = data_i[10*i +: 10];
            end
        end
    end

    always_comb begin : next_state
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        reg_d     = reg_q;
        data_d    = data_q;
        second_d  = second_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        ack_d     = '0;
        busy_d    = busy_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_i) state_d = ARB;
            end
            ARB: begin
                if (found) begin
                    grant_d  = pick_idx;
                    reg_d    = pick_reg;
                    data_d   = pick_data;
                    second_d = 1'b0;
                    busy_d   = 1'b1;
                    d_d      = latch_byte(pick_reg, pick_data[3:0]);
                    cnt_d    = '0;
                    state_d  = STROBE;
                end else begin
                    state_d = IDLE;
                end
            end
            STROBE: begin
                if (!ready_i) begin
                    cnt_d   = '0;
                    state_d = WAIT_HI;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (ready_i) begin
                    state_d = GAP;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (!second_q && is_freq(reg_q)) begin
                    second_d = 1'b1;
                    d_d      = {2'b00, data_q[9:4]};
                    cnt_d    = '0;
                    state_d  = STROBE;
                end else begin
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        ack_d[i] = (grant_q == 3'(i));
                    end
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                ptr_d   = (grant_q == LAST_REQ) ? 3'd0 : grant_q + 3'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        strobe_n_d = !((state_d == STROBE) || (state_d == WAIT_HI));
    end

    always_ff @(posedge clock_i or negedge res_n_i) begin : regs
        if (!res_n_i) begin
            state_q    <= IDLE;
            ptr_q      <= 3'd0;
            grant_q    <= 3'd0;
            reg_q      <= 3'd0;
            data_q     <= 10'd0;
            second_q   <= 1'b0;
            cnt_q      <= '0;
            strobe_n_q <= 1'b1;
            d_q        <= 8'd0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            reg_q      <= reg_d;
            data_q     <= data_d;
            second_q   <= second_d;
            cnt_q      <= cnt_d;
            strobe_n_q <= strobe_n_d;
            d_q        <= d_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign ack_o     = ack_q;
    assign busy_o    = busy_q;
    assign grant_o   = grant_q;
    assign ce_n_o    = strobe_n_q;
    assign we_n_o    = strobe_n_q;
    assign d_o       = d_q;
    assign timeout_o = timeout_q;

`ifdef SN76489_WR_SHADOW_EN
    logic [9:0] shadow_q [8];
    logic [9:0] shadow_val;

    // Stored value is what the chip actually received, not the raw request.
    always_comb begin : shadow_mask
        shadow_val = {6'd0, data_q[3:0]};
        if (is_freq(reg_q))       shadow_val = data_q;
        else if (reg_q == 3'd6)   shadow_val = {7'd0, data_q[2:0]};
    end

    always_ff @(posedge clock_i or negedge res_n_i) begin : shadow_file
        if (!res_n_i) begin
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= (i % 2 == 1) ? 10'h00F : 10'h000;
            end
        end else if (state_q == DONE) begin
            shadow_q[reg_q] <= shadow_val;
        end
    end

    assign shadow_data_o = shadow_q[shadow_addr_i];
`endif

endmodule

// File: tb/tb_sn76489_wr_arbiter.sv
// Self-checking bench for sn76489_wr_arbiter: chip ready model, byte/ack monitor, behavioural reference.
// Build with SN76489_WR_SHADOW_EN defined to also cover the shadow register file.

module tb_sn76489_wr_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned TMO = 64;

    logic             clk = 1'b0;
    logic             res_n;
    logic [N-1:0]     req;
    logic [3*N-1:0]   regs;
    logic [10*N-1:0]  datas;
    logic [N-1:0]     ack;
    logic             busy;
    logic [2:0]       grant;
    logic             ce_n;
    logic             we_n;
    logic [7:0]       d;
    logic             ready;
    logic             timeout;
`ifdef SN76489_WR_SHADOW_EN
    logic [2:0]       shadow_addr;
    logic [9:0]       shadow_data;
`endif

    int vectors     = 0;
    int miscompares = 0;

    int low_cycles = 3;
    bit stuck      = 1'b0;

    logic [7:0]   byte_q[$];
    logic [N-1:0] ack_q[$];
    int           strobe_start[$];
    int           strobe_end[$];
    int           tmo_cnt      = 0;
    int           last_low_len = 0;
    int           last_lat     = 0;
    int           cyc          = 0;

    int           m_ptr = 0;
    logic [9:0]   m_shadow [8];

    always #5 clk = ~clk;

    sn76489_wr_arbiter #(.NUM_REQ(N), .RDY_TIMEOUT(TMO)) dut (
        .clock_i   (clk),
        .res_n_i   (res_n),
        .req_i     (req),
        .reg_i     (regs),
        .data_i    (datas),
        .ack_o     (ack),
        .busy_o    (busy),
        .grant_o   (grant),
        .ce_n_o    (ce_n),
        .we_n_o    (we_n),
        .d_o       (d),
        .ready_i   (ready),
`ifdef SN76489_WR_SHADOW_EN
        .timeout_o     (timeout),
        .shadow_addr_i (shadow_addr),
        .shadow_data_o (shadow_data)
`else
        .timeout_o (timeout)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference encoding from the register map: latch byte plus optional data byte.
    task automatic model_bytes(input int r, input int dat, output logic [7:0] b0,
                               output logic [7:0] b1, output int nb);
        int nib;
        nib = (r == 6) ? (dat % 8) : (dat % 16);
        b0  = 8'(128 + r * 16 + nib);
        if ((r % 2 == 0) && (r != 6)) begin
            nb = 2;
            b1 = 8'((dat / 16) % 64);
        end else begin
            nb = 1;
            b1 = 8'd0;
        end
    endtask

    function automatic logic [9:0] model_masked(input int r, input int dat);
        if ((r % 2 == 0) && (r != 6)) return 10'(dat);
        if (r == 6) return 10'(dat % 8);
        return 10'(dat % 16);
    endfunction

    function automatic int model_next(input int ptr, input int mask);
        for (int off = 0; off < int'(N); off++) begin
            int c;
            c = (ptr + off) % int'(N);
            if (((mask >> c) & 1) == 1) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < 8; i++) m_shadow[i] = (i % 2 == 1) ? 10'h00F : 10'h000;
    endtask

    task automatic clear_obs();
        byte_q.delete();
        ack_q.delete();
        strobe_start.delete();
        strobe_end.delete();
        tmo_cnt = 0;
    endtask

    // Chip model: answers each strobe with ready low for low_cycles cycles.
    initial begin : chip
        ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!ce_n && !we_n && !stuck) begin
                ready = 1'b0;
                repeat (low_cycles) @(negedge clk);
                ready = 1'b1;
                while (!ce_n) @(negedge clk);
            end
        end
    end

    initial begin : monitor
        bit         prev_low = 1'b0;
        logic [7:0] cur      = 8'd0;
        int         len      = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (ack != '0) ack_q.push_back(ack);
            if (timeout) tmo_cnt++;
            check("we_n_eq_ce_n", 32'(we_n), 32'(ce_n));
            if (!ce_n) begin
                if (!prev_low) begin
                    cur = d;
                    byte_q.push_back(d);
                    strobe_start.push_back(cyc);
                    len = 0;
                end else begin
                    check("d_stable", 32'(d), 32'(cur));
                end
                len++;
                prev_low = 1'b1;
            end else begin
                if (prev_low) begin
                    last_low_len = len;
                    strobe_end.push_back(cyc);
                end
                prev_low = 1'b0;
            end
        end
    end

    task automatic do_write(input int k, input int r, input int dat, input int low, input bit scramble);
        logic [7:0] b0, b1;
        int nb, n, exp_tmo;
        clear_obs();
        low_cycles = low;
        regs[3*k +: 3]   = 3'(r);
        datas[10*k +: 10] = 10'(dat);
        req[k] = 1'b1;
        n = 0;
        while (ack[k] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            if (scramble && busy) begin
                regs[3*k +: 3]    = 3'($urandom);
                datas[10*k +: 10] = 10'($urandom);
            end
        end
        check("ack_seen", 32'(ack[k]), 32'd1);
        last_lat = n;
        req[k] = 1'b0;
        repeat (2) @(negedge clk);
        model_bytes(r, dat, b0, b1, nb);
        exp_tmo = (stuck || low > int'(TMO)) ? nb : 0;
        check("byte_count", 32'(byte_q.size()), 32'(nb));
        if (byte_q.size() > 0) check("latch_byte", 32'(byte_q[0]), 32'(b0));
        if (nb == 2 && byte_q.size() > 1) check("data_byte", 32'(byte_q[1]), 32'(b1));
        check("ack_count", 32'(ack_q.size()), 32'd1);
        if (ack_q.size() > 0) check("ack_vec", 32'(ack_q[0]), 32'(1 << k));
        check("timeouts", 32'(tmo_cnt), 32'(exp_tmo));
        check("grant", 32'(grant), 32'(k));
        check("busy_idle", 32'(busy), 32'd0);
        check("ce_n_idle", 32'(ce_n), 32'd1);
        m_ptr = (k + 1) % int'(N);
        m_shadow[r] = model_masked(r, dat);
    endtask

    task automatic rr_test(input int mask);
        int rr_r[N], rr_d[N];
        int order[$];
        logic [7:0] expb[$];
        logic [7:0] b0, b1;
        int p, pend, w, nb, n;
        clear_obs();
        low_cycles = 2;
        for (int i = 0; i < int'(N); i++) begin
            rr_r[i] = int'($urandom_range(0, 7));
            rr_d[i] = int'($urandom_range(0, 1023));
            regs[3*i +: 3]    = 3'(rr_r[i]);
            datas[10*i +: 10] = 10'(rr_d[i]);
        end
        p = m_ptr;
        pend = mask;
        while (pend != 0) begin
            w = model_next(p, pend);
            order.push_back(w);
            model_bytes(rr_r[w], rr_d[w], b0, b1, nb);
            expb.push_back(b0);
            if (nb == 2) expb.push_back(b1);
            m_shadow[rr_r[w]] = model_masked(rr_r[w], rr_d[w]);
            pend = pend & ~(1 << w);
            p = (w + 1) % int'(N);
        end
        req = N'(mask);
        n = 0;
        while (req != '0 && n < 2000) begin
            @(negedge clk);
            n++;
            req = req & ~ack;
        end
        check("rr_all_served", 32'(req), 32'd0);
        req = '0;
        repeat (2) @(negedge clk);
        check("rr_ack_count", 32'(ack_q.size()), 32'(order.size()));
        foreach (order[i]) begin
            if (i < ack_q.size()) check("rr_order", 32'(ack_q[i]), 32'(1 << order[i]));
        end
        check("rr_byte_count", 32'(byte_q.size()), 32'(expb.size()));
        foreach (expb[i]) begin
            if (i < byte_q.size()) check("rr_byte", 32'(byte_q[i]), 32'(expb[i]));
        end
        m_ptr = p;
    endtask

`ifdef SN76489_WR_SHADOW_EN
    task automatic check_shadow();
        for (int a = 0; a < 8; a++) begin
            shadow_addr = 3'(a);
            #1;
            check("shadow", 32'(shadow_data), 32'(m_shadow[a]));
        end
        @(negedge clk);
    endtask
`endif

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        logic [7:0] b0, b1;
        int nb, rdat;
        res_n = 1'b0;
        req   = '0;
        regs  = '0;
        datas = '0;
`ifdef SN76489_WR_SHADOW_EN
        shadow_addr = 3'd0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ce_n", 32'(ce_n), 32'd1);
        check("rst_we_n", 32'(we_n), 32'd1);
        check("rst_d", 32'(d), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        res_n = 1'b1;
        @(negedge clk);
`ifdef SN76489_WR_SHADOW_EN
        check_shadow();
`endif

        // All four at once from reset, then two while the pointer sits at 1.
        rr_test(4'hF);
        do_write(0, 1, 10'h005, 3, 1'b0);
        rr_test(4'h5);

        do_write(1, 0, 10'h3FE, 3, 1'b0);
        if (strobe_end.size() > 0 && strobe_start.size() > 1)
            check("gap_cycles", 32'(strobe_start[1] - strobe_end[0]), 32'd1);
        else
            check("gap_strobes", 32'(strobe_start.size()), 32'd2);

        do_write(2, 5, int'($urandom_range(0, 1023)), 1, 1'b0);
        check("min_latency", 32'(last_lat), 32'd5);

        do_write(3, 6, 10'h3FF, 2, 1'b0);
`ifdef SN76489_WR_SHADOW_EN
        check_shadow();
`endif

        for (int i = 0; i < 24; i++) begin
            do_write(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 1023)), int'($urandom_range(1, 5)), 1'b1);
        end

        // Ready never falls: STROBE times out after TMO cycles.
        stuck = 1'b1;
        do_write(0, 3, int'($urandom_range(0, 1023)), 3, 1'b0);
        check("strobe_tmo_len", 32'(last_low_len), 32'(TMO));
        stuck = 1'b0;

        // Ready stays low too long: WAIT_HI times out.
        do_write(1, 7, int'($urandom_range(0, 1023)), 70, 1'b0);
        check("wait_tmo_len", 32'(last_low_len), 32'(TMO + 1));
        n = 0;
        while (ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("ready_restored", 32'(ready), 32'd1);
        @(negedge clk);

        // Reset in the middle of a two-byte write.
        clear_obs();
        low_cycles = 10;
        rdat = int'($urandom_range(0, 1023));
        regs[6 +: 3]   = 3'd4;
        datas[20 +: 10] = 10'(rdat);
        req[2] = 1'b1;
        n = 0;
        while (!(ce_n === 1'b0 && ready === 1'b0) && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        check("in_wait_hi", 32'(ce_n), 32'd0);
        res_n = 1'b0;
        #1;
        check("arst_ce_n", 32'(ce_n), 32'd1);
        check("arst_we_n", 32'(we_n), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        repeat (15) @(negedge clk);
        check("arst_no_ack", 32'(ack_q.size()), 32'd0);
        model_reset();
        clear_obs();
        res_n = 1'b1;
        n = 0;
        while (ack[2] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        check("arst_ack_after", 32'(ack[2]), 32'd1);
        req[2] = 1'b0;
        repeat (2) @(negedge clk);
        model_bytes(4, rdat, b0, b1, nb);
        check("arst_byte_count", 32'(byte_q.size()), 32'(nb));
        if (byte_q.size() > 0) check("arst_latch", 32'(byte_q[0]), 32'(b0));
        if (byte_q.size() > 1) check("arst_data", 32'(byte_q[1]), 32'(b1));
        check("arst_ack_count", 32'(ack_q.size()), 32'd1);
        m_ptr = 3;
        m_shadow[4] = model_masked(4, rdat);

        rr_test(4'hB);
`ifdef SN76489_WR_SHADOW_EN
        check_shadow();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
